// File: rtl/cache_pkg.sv
// Shared cache geometry and refill-FSM state encoding.
package cache_pkg;

   localparam int unsigned TAG_W           = 6;
   localparam int unsigned INDEX_W         = 6;
   localparam int unsigned OFFSET_W        = 4;
   localparam int unsigned WORDS_PER_BLOCK = 8;
   localparam int unsigned ADDR_W          = TAG_W + INDEX_W + OFFSET_W;
   localparam int unsigned DATA_W          = 16;
   localparam int unsigned BLOCK_W         = TAG_W + INDEX_W;
   localparam int unsigned RCV_W           = $clog2(WORDS_PER_BLOCK);
   localparam int unsigned REQ_W           = RCV_W + 1;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_t;

endpackage

// File: rtl/dff.sv
// Codebase storage cell: write-enabled flop with synchronous active-high reset to zero.
module dff #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wen,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst)      q <= '0;
      else if (wen) q <= d;
   end

endmodule

// File: rtl/fill_counter.sv
// Up-counter with clear priority over increment, built on the dff cell.
module fill_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] w_d;
   logic         w_wen;

   assign w_d   = clr ? '0 : q + W'(1);
   assign w_wen = clr | inc;

   dff #(.W(W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .wen (w_wen),
      .d   (w_d),
      .q   (q)
   );

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: requests the eight words of a block from memory and
// streams returned words into the cache, writing tag/valid on the last word.
module cache_fill_fsm
   import cache_pkg::*;
#(
   parameter int unsigned WORDS       = WORDS_PER_BLOCK,
   parameter int unsigned MEM_LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              miss_detected,
   input  logic [ADDR_W-1:0] miss_address,
   input  logic              memory_data_valid,
   input  logic [DATA_W-1:0] memory_data,
   output logic              mem_read_en,
   output logic [ADDR_W-1:0] mem_req_address,
   output logic              fsm_busy,
   output logic              write_data_array,
   output logic              write_tag_array,
   output logic [ADDR_W-1:0] memory_address,
   output logic [DATA_W-1:0] memory_data_out
);

   if (WORDS != WORDS_PER_BLOCK || MEM_LATENCY == 0) begin : g_bad_cfg
      $error("cache_fill_fsm: WORDS must match cache geometry and MEM_LATENCY must be nonzero");
   end

   fill_state_t        r_state;
   fill_state_t        w_state_nxt;
   logic [0:0]         w_state_q;
   logic [BLOCK_W-1:0] r_base;
   logic [REQ_W-1:0]   r_req_cnt;
   logic [RCV_W-1:0]   r_rcv_cnt;
   logic               w_base_wen;
   logic               w_cnt_clr;
   logic               w_req_inc;
   logic               w_rcv_inc;
   logic               w_unused;

   // Byte offset of the missing address is irrelevant: refill always starts at word 0.
   assign w_unused = ^miss_address[OFFSET_W-1:0];

   dff #(.W(1)) u_state (
      .clk (clk),
      .rst (rst),
      .wen (1'b1),
      .d   (1'(w_state_nxt)),
      .q   (w_state_q)
   );
   assign r_state = fill_state_t'(w_state_q);

   dff #(.W(BLOCK_W)) u_base (
      .clk (clk),
      .rst (rst),
      .wen (w_base_wen),
      .d   (miss_address[ADDR_W-1:OFFSET_W]),
      .q   (r_base)
   );

   fill_counter #(.W(REQ_W)) u_req_cnt (
      .clk (clk),
      .rst (rst),
      .clr (w_cnt_clr),
      .inc (w_req_inc),
      .q   (r_req_cnt)
   );

   fill_counter #(.W(RCV_W)) u_rcv_cnt (
      .clk (clk),
      .rst (rst),
      .clr (w_cnt_clr),
      .inc (w_rcv_inc),
      .q   (r_rcv_cnt)
   );

   // Next state, counter controls and outputs; request and receive sides run independently in FILL.
   always_comb begin
      w_state_nxt      = r_state;
      w_base_wen       = 1'b0;
      w_cnt_clr        = 1'b0;
      w_req_inc        = 1'b0;
      w_rcv_inc        = 1'b0;
      mem_read_en      = 1'b0;
      mem_req_address  = '0;
      fsm_busy         = 1'b0;
      write_data_array = 1'b0;
      write_tag_array  = 1'b0;
      memory_address   = '0;
      memory_data_out  = '0;

      case (r_state)
         IDLE: begin
            if (miss_detected) begin
               w_base_wen  = 1'b1;
               w_cnt_clr   = 1'b1;
               w_state_nxt = FILL;
            end
         end
         FILL: begin
            fsm_busy       = 1'b1;
            memory_address = {r_base, r_rcv_cnt, 1'b0};
            if (!r_req_cnt[REQ_W-1]) begin
               mem_read_en     = 1'b1;
               mem_req_address = {r_base, r_req_cnt[RCV_W-1:0], 1'b0};
               w_req_inc       = 1'b1;
            end
            if (memory_data_valid) begin
               write_data_array = 1'b1;
               memory_data_out  = memory_data;
               w_rcv_inc        = 1'b1;
               if (r_rcv_cnt == RCV_W'(WORDS_PER_BLOCK - 1)) begin
                  write_tag_array = 1'b1;
                  w_state_nxt     = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm against a block-level refill model.
module tb_cache_fill_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic        miss_detected;
   logic [15:0] miss_address;
   logic        memory_data_valid;
   logic [15:0] memory_data;
   logic        mem_read_en;
   logic [15:0] mem_req_address;
   logic        fsm_busy;
   logic        write_data_array;
   logic        write_tag_array;
   logic [15:0] memory_address;
   logic [15:0] memory_data_out;

   always #5 clk = ~clk;

   cache_fill_fsm dut (
      .clk               (clk),
      .rst               (rst),
      .miss_detected     (miss_detected),
      .miss_address      (miss_address),
      .memory_data_valid (memory_data_valid),
      .memory_data       (memory_data),
      .mem_read_en       (mem_read_en),
      .mem_req_address   (mem_req_address),
      .fsm_busy          (fsm_busy),
      .write_data_array  (write_data_array),
      .write_tag_array   (write_tag_array),
      .memory_address    (memory_address),
      .memory_data_out   (memory_data_out)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: refill in progress, block base, words requested, words received.
   logic        m_busy = 1'b0;
   logic [15:0] m_base = 16'h0;
   int          m_req  = 0;
   int          m_rcv  = 0;

   // Memory model: pending returns with due cycle and data.
   int          due_q[$];
   logic [15:0] dat_q[$];
   int          last_due  = 0;
   logic [15:0] data_base = 16'hA000;
   int          gap_word  = -1;
   int          gap_len   = 0;

   // {busy, rd_en, req_addr, wr_data, wr_tag, mem_addr, data_out}
   logic [51:0] obs;
   logic [51:0] exp_v;

   task automatic step(input logic miss, input logic [15:0] addr, input logic r, input logic noise);
      logic        v;
      logic [15:0] d;
      logic        e_rd, e_wda, e_tag;
      logic [15:0] e_raddr, e_maddr, e_dout;
      int          due;
      @(negedge clk);
      v = 1'b0;
      d = 16'h0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
         v = 1'b1;
         d = dat_q[0];
         void'(due_q.pop_front());
         void'(dat_q.pop_front());
      end else if (noise && !m_busy) begin
         v = 1'($urandom_range(0, 1));
         d = 16'($urandom);
      end
      rst               = r;
      miss_detected     = miss;
      miss_address      = addr;
      memory_data_valid = v;
      memory_data       = d;
      #1;
      e_rd    = m_busy && (m_req < 8);
      e_raddr = e_rd ? m_base + 16'(2 * m_req) : 16'h0;
      e_wda   = m_busy && v;
      e_tag   = e_wda && (m_rcv == 7);
      e_maddr = m_busy ? m_base + 16'(2 * m_rcv) : 16'h0;
      e_dout  = e_wda ? d : 16'h0;
      exp_v   = {m_busy, e_rd, e_raddr, e_wda, e_tag, e_maddr, e_dout};
      obs     = {fsm_busy, mem_read_en, mem_req_address, write_data_array,
                 write_tag_array, memory_address, memory_data_out};
      if (r) begin
         m_busy = 1'b0; m_base = 16'h0; m_req = 0; m_rcv = 0;
         due_q.delete(); dat_q.delete(); last_due = 0;
      end else if (!m_busy) begin
         if (miss) begin
            m_busy = 1'b1; m_base = addr & 16'hFFF0; m_req = 0; m_rcv = 0; last_due = 0;
         end
      end else begin
         if (e_rd) begin
            due = cyc + 4 + ((gap_word >= 0 && m_req >= gap_word) ? gap_len : 0);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            due_q.push_back(due);
            dat_q.push_back(data_base + 16'(m_req));
            m_req++;
         end
         if (v) begin
            m_rcv++;
            if (m_rcv == 8) m_busy = 1'b0;
         end
      end
      cyc++;
   endtask

   task automatic test_reset();
      step(1'b0, 16'h0, 1'b1, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 16'($urandom), 1'b0, 1'b1);
         checks++;
         if (obs !== 52'h0 || obs !== exp_v) begin
            errors++;
            $display("FAIL reset_idle cyc %0d got %h exp %h", cyc, obs, exp_v);
         end
      end
   endtask

   task automatic test_basic();
      int busy_n = 0, wr_n = 0, tag_n = 0, tag_t = -1;
      data_base = 16'hA000; gap_word = -1; gap_len = 0;
      for (int t = 0; t < 15; t++) begin
         step(t == 0, 16'h1A37, 1'b0, 1'b0);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL basic t %0d got %h exp %h", t, obs, exp_v);
         end
         if (fsm_busy) busy_n++;
         if (write_data_array) wr_n++;
         if (write_tag_array) begin tag_n++; tag_t = t; end
         if (t >= 1 && t <= 8) begin
            checks++;
            if (!(mem_read_en === 1'b1 && mem_req_address === 16'h1A30 + 16'(2 * (t - 1)))) begin
               errors++;
               $display("FAIL basic_req t %0d got %h exp %h", t, mem_req_address, 16'h1A30 + 16'(2 * (t - 1)));
            end
         end
         if (t >= 5 && t <= 12) begin
            checks++;
            if (!(write_data_array === 1'b1 && memory_address === 16'h1A30 + 16'(2 * (t - 5))
                  && memory_data_out === 16'hA000 + 16'(t - 5))) begin
               errors++;
               $display("FAIL basic_wr t %0d got %h/%h", t, memory_address, memory_data_out);
            end
         end
      end
      checks++;
      if (busy_n != 12 || wr_n != 8 || tag_n != 1 || tag_t != 12) begin
         errors++;
         $display("FAIL basic_counts got busy %0d wr %0d tag %0d@%0d exp 12 8 1@12", busy_n, wr_n, tag_n, tag_t);
      end
   endtask

   task automatic test_gap();
      int busy_n = 0, wr_n = 0, tag_n = 0;
      data_base = 16'($urandom); gap_word = 4; gap_len = 3;
      for (int t = 0; t < 18; t++) begin
         step(t == 0, 16'h1A37, 1'b0, 1'b0);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL gap t %0d got %h exp %h", t, obs, exp_v);
         end
         if (fsm_busy) busy_n++;
         if (write_data_array) wr_n++;
         if (write_tag_array) tag_n++;
      end
      checks++;
      if (busy_n != 15 || wr_n != 8 || tag_n != 1) begin
         errors++;
         $display("FAIL gap_counts got busy %0d wr %0d tag %0d exp 15 8 1", busy_n, wr_n, tag_n);
      end
      gap_word = -1; gap_len = 0;
   endtask

   task automatic test_back_to_back();
      int busy_n = 0, first2 = -1;
      data_base = 16'($urandom);
      for (int t = 0; t < 28; t++) begin
         step(t == 0 || (t >= 3 && t <= 13), (t == 0) ? 16'h1A37 : 16'hFFF0, 1'b0, 1'b0);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL b2b t %0d got %h exp %h", t, obs, exp_v);
         end
         if (fsm_busy) busy_n++;
         if (first2 < 0 && mem_read_en && mem_req_address === 16'hFFF0) first2 = t;
      end
      checks++;
      if (busy_n != 24 || first2 != 14) begin
         errors++;
         $display("FAIL b2b_counts got busy %0d req2@%0d exp 24 14", busy_n, first2);
      end
   endtask

   task automatic test_reset_mid();
      int wr_n = 0;
      logic [15:0] a;
      data_base = 16'($urandom);
      a = 16'($urandom);
      for (int t = 0; t < 9; t++) begin
         step(t == 0, a, t == 7, 1'b0);
         if (t == 8) begin
            checks++;
            if (obs !== 52'h0 || obs !== exp_v) begin
               errors++;
               $display("FAIL rst_mid t %0d got %h exp 0", t, obs);
            end
         end
      end
      a = 16'($urandom);
      for (int t = 0; t < 14; t++) begin
         step(t == 0, a, 1'b0, 1'b0);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL rst_refill t %0d got %h exp %h", t, obs, exp_v);
         end
         if (write_data_array) wr_n++;
      end
      checks++;
      if (wr_n != 8) begin
         errors++;
         $display("FAIL rst_refill_count got %0d exp 8", wr_n);
      end
   endtask

   task automatic test_edges();
      logic [15:0] addrs [2];
      logic [15:0] bases [2];
      addrs[0] = 16'h0000; addrs[1] = 16'hFFFF;
      bases[0] = 16'h0000; bases[1] = 16'hFFF0;
      for (int k = 0; k < 2; k++) begin
         int bad = 0;
         data_base = 16'($urandom);
         for (int t = 0; t < 14; t++) begin
            step(t == 0, addrs[k], 1'b0, 1'b0);
            checks++;
            if (obs !== exp_v) begin
               errors++;
               $display("FAIL edge%0d t %0d got %h exp %h", k, t, obs, exp_v);
            end
            if (mem_read_en && (mem_req_address & 16'hFFF0) !== bases[k]) bad++;
            if (fsm_busy && (memory_address & 16'hFFF0) !== bases[k]) bad++;
         end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL edge%0d_block got %0d out-of-block addrs exp 0", k, bad);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 20; n++) begin
         logic [15:0] a;
         int hold;
         a         = 16'($urandom);
         data_base = 16'($urandom);
         gap_word  = $urandom_range(0, 8) == 8 ? -1 : int'($urandom_range(0, 7));
         gap_len   = $urandom_range(0, 5);
         hold      = $urandom_range(0, 3);
         for (int t = 0; t < 26; t++) begin
            step(t <= hold || ($urandom_range(0, 3) == 0), a, 1'b0, 1'b1);
            checks++;
            if (obs !== exp_v) begin
               errors++;
               $display("FAIL random n %0d t %0d got %h exp %h", n, t, obs, exp_v);
            end
         end
      end
      gap_word = -1; gap_len = 0;
      for (int t = 0; t < 20; t++) begin
         step(1'b0, 16'h0, 1'b0, 1'b0);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL drain t %0d got %h exp %h", t, obs, exp_v);
         end
      end
   endtask

   initial begin
      rst = 1'b1; miss_detected = 1'b0; miss_address = 16'h0;
      memory_data_valid = 1'b0; memory_data = 16'h0;
      test_reset();
      test_basic();
      test_gap();
      test_back_to_back();
      test_reset_mid();
      test_edges();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
